// File: rtl/tcb_uart_man.sv
// UART-to-TCB debug bridge (bus manager side).
// A host sends command frames over 8N1 UART; the bridge issues one TCB
// transfer per frame and returns read data (reads) and a status byte.
//
// Handshake: tcb_vld together with tcb_wen/tcb_adr/tcb_wdt is held stable
// until tcb_rdy is sampled high; the transfer happens in the cycle where
// tcb_vld & tcb_rdy, and tcb_rdt/tcb_err are sampled DLY cycles later.
module tcb_uart_man #(
  parameter int unsigned N_BIT = 4,
  parameter int unsigned ADW   = 32,
  parameter int unsigned DBW   = 32,
  parameter int unsigned DLY   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             uart_rxd,
  output logic             uart_txd,
  output logic             tcb_vld,
  output logic             tcb_wen,
  output logic [ADW-1:0]   tcb_adr,
  output logic [DBW/8-1:0] tcb_ben,
  output logic [DBW-1:0]   tcb_wdt,
  input  logic             tcb_rdy,
  input  logic [DBW-1:0]   tcb_rdt,
  input  logic             tcb_err,
  output logic             busy
);

  localparam int unsigned CW = $clog2(N_BIT);

  localparam logic [2:0] RX_CMD  = 3'd0;
  localparam logic [2:0] RX_ADR  = 3'd1;
  localparam logic [2:0] RX_WDT  = 3'd2;
  localparam logic [2:0] BUS_REQ = 3'd3;
  localparam logic [2:0] BUS_RSP = 3'd4;
  localparam logic [2:0] TX_RDT  = 3'd5;
  localparam logic [2:0] TX_STS  = 3'd6;

  localparam logic [1:0] ADR_LAST = 2'(ADW/8 - 1);

  assign tcb_ben = '1;

  // ---------------------------------------------------------------- RX
  logic          rxd_s1, rxd_s2, rxd_q;
  logic          rx_busy;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          rx_smp, rx_vld, rx_ferr;

  // bit 0 is the start bit, 1..8 data, 9 the stop bit
  assign rx_smp  = rx_busy && (rx_cnt == '0);
  assign rx_vld  = rx_smp && (rx_bit == 4'd9) && rxd_s2;
  assign rx_ferr = rx_smp && (rx_bit == 4'd9) && !rxd_s2;

  // synchronize the line, detect start, sample each bit at mid-bit
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_s1  <= 1'b1;
      rxd_s2  <= 1'b1;
      rxd_q   <= 1'b1;
      rx_busy <= 1'b0;
      rx_cnt  <= '0;
      rx_bit  <= 4'd0;
      rx_sh   <= 8'h00;
    end else begin
      rxd_s1 <= uart_rxd;
      rxd_s2 <= rxd_s1;
      rxd_q  <= rxd_s2;
      if (!rx_busy) begin
        if (rxd_q && !rxd_s2) begin
          rx_busy <= 1'b1;
          rx_cnt  <= CW'(N_BIT/2 - 1);
          rx_bit  <= 4'd0;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - 1'b1;
      end else begin
        rx_cnt <= CW'(N_BIT - 1);
        rx_bit <= rx_bit + 4'd1;
        if (rx_bit == 4'd0) begin
          if (rxd_s2) rx_busy <= 1'b0;  // start glitch
        end else if (rx_bit == 4'd9) begin
          rx_busy <= 1'b0;
        end else begin
          rx_sh <= {rxd_s2, rx_sh[7:1]};
        end
      end
    end
  end

  // ---------------------------------------------------------------- TX
  logic          tx_busy;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_sh;
  logic          tx_rdy, tx_load;
  logic [7:0]    tx_byte;

  // ready while idle or in the last cycle of a stop bit (back-to-back)
  assign tx_rdy = !tx_busy || ((tx_bit == 4'd9) && (tx_cnt == '0));

  // serialize start, 8 data bits LSB first, stop
  always_ff @(posedge clk) begin
    if (rst) begin
      uart_txd <= 1'b1;
      tx_busy  <= 1'b0;
      tx_cnt   <= '0;
      tx_bit   <= 4'd0;
      tx_sh    <= '1;
    end else if (tx_load) begin
      uart_txd <= 1'b0;
      tx_busy  <= 1'b1;
      tx_cnt   <= CW'(N_BIT - 1);
      tx_bit   <= 4'd0;
      tx_sh    <= {1'b1, tx_byte};
    end else if (tx_busy) begin
      if (tx_cnt != '0) begin
        tx_cnt <= tx_cnt - 1'b1;
      end else if (tx_bit == 4'd9) begin
        tx_busy <= 1'b0;
      end else begin
        tx_cnt   <= CW'(N_BIT - 1);
        tx_bit   <= tx_bit + 4'd1;
        uart_txd <= tx_sh[0];
        tx_sh    <= {1'b1, tx_sh[8:1]};
      end
    end
  end

  // --------------------------------------------------------------- FSM
  logic [2:0]     state;
  logic [1:0]     cnt;
  logic [DBW-1:0] rsp_sh;
  logic [7:0]     sts;

  // pick the next response byte for the serializer
  always_comb begin
    tx_load = 1'b0;
    tx_byte = 8'h00;
    case (state)
      TX_RDT: begin
        tx_load = tx_rdy;
        tx_byte = rsp_sh[7:0];
      end
      TX_STS: begin
        tx_load = tx_rdy && (cnt == 2'd0);
        tx_byte = sts;
      end
      default: ;
    endcase
  end

  // command parsing, bus transfer and response sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RX_CMD;
      cnt     <= 2'd0;
      busy    <= 1'b0;
      tcb_vld <= 1'b0;
      tcb_wen <= 1'b0;
      tcb_adr <= '0;
      tcb_wdt <= '0;
      rsp_sh  <= '0;
      sts     <= 8'h00;
    end else begin
      case (state)
        RX_CMD: if (rx_vld) begin
          cnt <= 2'd0;
          if (rx_sh == 8'h00 || rx_sh == 8'h80) begin
            tcb_wen <= rx_sh[7];
            busy    <= 1'b1;
            state   <= RX_ADR;
          end else begin
            sts   <= 8'hFF;
            state <= TX_STS;
          end
        end
        RX_ADR: if (rx_ferr) begin
          state <= RX_CMD;
          busy  <= 1'b0;
          cnt   <= 2'd0;
        end else if (rx_vld) begin
          tcb_adr <= (tcb_adr >> 8) | (ADW'(rx_sh) << (ADW - 8));
          if (cnt == ADR_LAST) begin
            cnt <= 2'd0;
            if (tcb_wen) begin
              state <= RX_WDT;
            end else begin
              state   <= BUS_REQ;
              tcb_vld <= 1'b1;
            end
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        RX_WDT: if (rx_ferr) begin
          state <= RX_CMD;
          busy  <= 1'b0;
          cnt   <= 2'd0;
        end else if (rx_vld) begin
          tcb_wdt <= {rx_sh, tcb_wdt[DBW-1:8]};
          if (cnt == 2'd3) begin
            cnt     <= 2'd0;
            state   <= BUS_REQ;
            tcb_vld <= 1'b1;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        BUS_REQ: if (tcb_vld && tcb_rdy) begin
          tcb_vld <= 1'b0;
          state   <= BUS_RSP;
          cnt     <= 2'd0;
          if (DLY == 0) begin
            rsp_sh <= tcb_rdt;
            sts    <= {7'd0, tcb_err};
          end
        end
        BUS_RSP: begin
          if (DLY != 0) begin
            rsp_sh <= tcb_rdt;
            sts    <= {7'd0, tcb_err};
          end
          state <= tcb_wen ? TX_STS : TX_RDT;
          cnt   <= 2'd0;
        end
        TX_RDT: if (tx_load) begin
          rsp_sh <= rsp_sh >> 8;
          if (cnt == 2'd3) begin
            state <= TX_STS;
            cnt   <= 2'd0;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        TX_STS: if (tx_rdy) begin
          if (cnt == 2'd0) begin
            cnt <= 2'd1;  // status byte handed to the serializer
          end else begin
            state <= RX_CMD;
            busy  <= 1'b0;
            cnt   <= 2'd0;
          end
        end
        default: begin
          state <= RX_CMD;
          cnt   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tcb_uart_man.sv
// Directed bench for tcb_uart_man: drives UART command frames, plays a TCB
// subordinate, decodes the UART response and checks it against exp_q.
module tb_tcb_uart_man;

  localparam int N_BIT = 4;
  localparam int ADW   = 32;
  localparam int DBW   = 32;
  localparam int DLY   = 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             uart_rxd = 1'b1;
  logic             uart_txd;
  logic             tcb_vld, tcb_wen, busy;
  logic [ADW-1:0]   tcb_adr;
  logic [DBW/8-1:0] tcb_ben;
  logic [DBW-1:0]   tcb_wdt;
  logic             tcb_rdy = 1'b0;
  logic [DBW-1:0]   tcb_rdt = '0;
  logic             tcb_err = 1'b0;

  tcb_uart_man #(.N_BIT(N_BIT), .ADW(ADW), .DBW(DBW), .DLY(DLY)) dut (
    .clk(clk), .rst(rst), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
    .tcb_vld(tcb_vld), .tcb_wen(tcb_wen), .tcb_adr(tcb_adr),
    .tcb_ben(tcb_ben), .tcb_wdt(tcb_wdt), .tcb_rdy(tcb_rdy),
    .tcb_rdt(tcb_rdt), .tcb_err(tcb_err), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] mon_q[$];
  int mon_ferr = 0;

  // bus observation, shared with the subordinate model
  int             vld_cyc  = 0;
  int             n_xfer   = 0;
  int             stab_err = 0;
  logic [ADW-1:0] x_adr = '0;
  logic           x_wen = 1'b0;
  logic [DBW-1:0] x_wdt = '0;
  logic [3:0]     x_ben = '0;
  logic [DBW-1:0] rsp_rdt = '0;
  logic           rsp_err = 1'b0;
  logic           hs, p_vld, p_rdy, p_wen;
  logic [ADW-1:0] p_adr;
  logic [DBW-1:0] p_wdt;

  // subordinate model: read data/err valid exactly one cycle after transfer
  initial begin
    p_vld = 1'b0; p_rdy = 1'b0; p_wen = 1'b0; p_adr = '0; p_wdt = '0;
    forever begin
      @(posedge clk);
      hs = tcb_vld && tcb_rdy;
      if (tcb_vld) vld_cyc++;
      if (hs) begin
        n_xfer++;
        x_adr = tcb_adr; x_wen = tcb_wen; x_wdt = tcb_wdt; x_ben = tcb_ben;
      end
      if (!rst && p_vld && !p_rdy && tcb_vld &&
          ({tcb_wen, tcb_adr, tcb_wdt} !== {p_wen, p_adr, p_wdt})) stab_err++;
      p_vld = tcb_vld; p_rdy = tcb_rdy; p_wen = tcb_wen;
      p_adr = tcb_adr; p_wdt = tcb_wdt;
      #1;
      tcb_rdt = hs ? rsp_rdt : 32'hBAD0_BAD0;
      tcb_err = hs ? rsp_err : 1'b0;
    end
  end

  // UART response decoder
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (uart_txd === 1'b0 && !rst) begin
        repeat (N_BIT/2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (N_BIT) @(negedge clk);
          b[i] = uart_txd;
        end
        repeat (N_BIT) @(negedge clk);
        if (uart_txd !== 1'b1) mon_ferr++;
        mon_q.push_back(b);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop);
    uart_rxd = 1'b0;
    repeat (N_BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (N_BIT) @(negedge clk);
    end
    uart_rxd = stop;
    repeat (N_BIT) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (N_BIT) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] cmd, input logic [31:0] adr, input logic [31:0] wdt);
    uart_send(cmd, 1'b1);
    for (int i = 0; i < 4; i++) uart_send(adr[8*i +: 8], 1'b1);
    if (cmd == 8'h80)
      for (int i = 0; i < 4; i++) uart_send(wdt[8*i +: 8], 1'b1);
  endtask

  task automatic wait_vld(input string tag);
    int k = 0;
    while (tcb_vld !== 1'b1 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_vld_seen"}, tcb_vld, 1'b1);
  endtask

  task automatic expect_resp(input string tag, input bit chk_busy);
    int n = exp_q.size();
    int k = 0;
    logic [7:0] e, o;
    while (mon_q.size() < n && k < 4000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_resp_count"}, mon_q.size(), n);
    if (chk_busy) begin
      check({tag, "_busy_during_stop"}, busy, 1'b1);
      k = 0;
      while (busy !== 1'b0 && k < 10) begin
        @(negedge clk);
        k++;
      end
      check({tag, "_busy_fall"}, (k >= 1 && k <= 2), 1'b1);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (mon_q.size() > 0) ? mon_q.pop_front() : 8'hxx;
      check({tag, "_resp_byte"}, o, e);
    end
    mon_q.delete();
    repeat (N_BIT) @(negedge clk);
  endtask

  int v0, x0;

  initial begin
    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_txd", uart_txd, 1'b1);
    check("rst_vld", tcb_vld, 1'b0);
    check("rst_wen", tcb_wen, 1'b0);
    check("rst_adr", tcb_adr, 32'h0);
    check("rst_ben", tcb_ben, 4'hF);
    check("rst_wdt", tcb_wdt, 32'h0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // write, subordinate always ready
    tcb_rdy = 1'b1; rsp_err = 1'b0;
    v0 = vld_cyc; x0 = n_xfer;
    send_cmd(8'h80, 32'h0000_0010, 32'hDEAD_BEEF);
    exp_q.push_back(8'h00);
    expect_resp("wr", 1'b1);
    check("wr_xfers", n_xfer - x0, 1);
    check("wr_vld_cycles", vld_cyc - v0, 1);
    check("wr_wen", x_wen, 1'b1);
    check("wr_adr", x_adr, 32'h0000_0010);
    check("wr_wdt", x_wdt, 32'hDEAD_BEEF);
    check("wr_ben", x_ben, 4'hF);

    // read with 5 wait states
    tcb_rdy = 1'b0; rsp_rdt = 32'h1234_5678;
    send_cmd(8'h00, 32'h0000_0004, 32'h0);
    wait_vld("rd");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rd_vld_hold", tcb_vld, 1'b1);
    end
    check("rd_adr_live", tcb_adr, 32'h0000_0004);
    check("rd_wen_live", tcb_wen, 1'b0);
    tcb_rdy = 1'b1;
    @(negedge clk);
    check("rd_vld_drop", tcb_vld, 1'b0);
    check("rd_xfer_adr", x_adr, 32'h0000_0004);
    exp_q.push_back(8'h78); exp_q.push_back(8'h56);
    exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    exp_q.push_back(8'h00);
    expect_resp("rd", 1'b1);
    check("rd_stable", stab_err, 0);

    // bus error on write
    rsp_err = 1'b1;
    send_cmd(8'h80, 32'h0000_0100, 32'h0BAD_F00D);
    exp_q.push_back(8'h01);
    expect_resp("err", 1'b1);
    rsp_err = 1'b0;

    // invalid command byte
    x0 = n_xfer; v0 = vld_cyc;
    uart_send(8'h55, 1'b1);
    exp_q.push_back(8'hFF);
    expect_resp("inv", 1'b0);
    check("inv_no_vld", vld_cyc - v0, 0);
    check("inv_busy", busy, 1'b0);

    // framing error, then a good read frame
    x0 = n_xfer;
    rsp_rdt = 32'hCAFE_F00D;
    uart_send(8'h00, 1'b0);
    send_cmd(8'h00, 32'h0000_0008, 32'h0);
    exp_q.push_back(8'h0D); exp_q.push_back(8'hF0);
    exp_q.push_back(8'hFE); exp_q.push_back(8'hCA);
    exp_q.push_back(8'h00);
    expect_resp("ferr", 1'b1);
    check("ferr_xfers", n_xfer - x0, 1);
    check("ferr_adr", x_adr, 32'h0000_0008);
    check("ferr_wen", x_wen, 1'b0);

    // reset while a transfer is pending
    tcb_rdy = 1'b0;
    send_cmd(8'h80, 32'h0000_0020, 32'h4433_2211);
    wait_vld("mrst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_vld", tcb_vld, 1'b0);
    check("mrst_txd", uart_txd, 1'b1);
    check("mrst_busy", busy, 1'b0);
    check("mrst_adr", tcb_adr, 32'h0);
    rst = 1'b0;
    tcb_rdy = 1'b1;
    repeat (4) @(negedge clk);
    x0 = n_xfer;
    send_cmd(8'h80, 32'h0000_0030, 32'h1122_3344);
    exp_q.push_back(8'h00);
    expect_resp("post_rst", 1'b1);
    check("post_rst_xfers", n_xfer - x0, 1);
    check("post_rst_adr", x_adr, 32'h0000_0030);
    check("post_rst_wdt", x_wdt, 32'h1122_3344);

    check("tx_stop_bits", mon_ferr, 0);
    check("vld_stable", stab_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tcb_uart_man.md
Name: tcb_uart_man

Overview:
- UART-to-TCB debug bridge: receives command frames on a UART line and issues TCB transfers as a bus manager.
- Returns read data and a status byte over UART.
- It is the manager-side counterpart of the TCB UART subordinate peripheral, for host/JTAG-less bring-up access to any TCB subordinate.
- Half-duplex command/response; one outstanding TCB transfer at a time.

Parameters:
- N_BIT, 4, clock cycles per UART bit (minimum 4), fixed 8N1 framing
- ADW, 32, TCB address width (multiple of 8, max 32)
- DBW, 32, TCB data width (fixed 32 in this block)
- DLY, 1, TCB read/response delay in cycles after vld&rdy (0 or 1)

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- uart_rxd  input  1  UART receive line, asynchronous, idle high
- uart_txd  output  1  UART transmit line, idle high
- tcb_vld  output  1  TCB transfer valid
- tcb_wen  output  1  TCB write enable (1 write, 0 read)
- tcb_adr  output  ADW  TCB address
- tcb_ben  output  DBW/8  TCB byte enable, always all ones
- tcb_wdt  output  DBW  TCB write data
- tcb_rdy  input  1  TCB ready; transfer happens on vld&rdy
- tcb_rdt  input  DBW  TCB read data, valid DLY cycles after transfer
- tcb_err  input  1  TCB error, valid DLY cycles after transfer
- busy  output  1  high from a valid command byte until the last response stop bit

Behaviour:
- Reset values: uart_txd=1, tcb_vld=0, tcb_wen=0, tcb_adr=0, tcb_ben=all ones, tcb_wdt=0, busy=0; FSM=RX_CMD; RX/TX baud counters idle.
- RX front end: 2-flop synchronizer on uart_rxd.
  - Start detected on a falling edge while the receiver is idle.
  - Baud counter samples at mid-bit: first sample N_BIT/2 cycles after the edge, then every N_BIT cycles.
  - Start bit re-checked at mid-bit; if high, treat as a glitch and return to idle.
  - Data LSB first; stop bit sampled.
  - Byte strobe rx_vld pulses 1 cycle at the stop-bit sample.
  - Framing error (stop=0): no strobe; FSM returns to RX_CMD and the partial frame is discarded.
- Frame format, all multi-byte fields LSB first:
  - cmd byte: 0x00=read, 0x80=write.
  - ADW/8 address bytes.
  - Write only: 4 data bytes.
- FSM states:
  - RX_CMD: on rx_vld, 0x00/0x80 latch wen, go to RX_ADR, busy=1. Any other byte: go to TX_STS with status 0xFF, no bus access.
  - RX_ADR: shift bytes into tcb_adr; after ADW/8 bytes go to RX_WDT if wen, else BUS_REQ.
  - RX_WDT: shift 4 bytes into tcb_wdt, then go to BUS_REQ.
  - BUS_REQ: tcb_vld=1 starting the cycle after the last byte strobe. Hold vld/wen/adr/wdt stable until tcb_rdy; no timeout. On vld&rdy, deassert vld next cycle and go to BUS_RSP.
  - BUS_RSP: wait DLY cycles (DLY=0 samples in the transfer cycle). Capture tcb_rdt into the response shift register and tcb_err into status (0x00 ok, 0x01 err). Go to TX_RDT if read, else TX_STS.
  - TX_RDT: transmit the 4 captured read bytes.
  - TX_STS: transmit the status byte, then go to RX_CMD, busy=0.
- TX serializer:
  - Start bit begins the cycle after the FSM loads a byte.
  - 10 bits of N_BIT cycles each: start 0, 8 data LSB first, stop 1.
  - Next byte starts back-to-back after the stop bit.
- Read data is transmitted even when tcb_err=1.
- RX bytes arriving while in BUS_REQ, BUS_RSP, TX_RDT or TX_STS are ignored (dropped).
- Byte counter: 2 bits, wraps at field length; cleared on every state entry.
- Reset mid-operation: all outputs return to reset values on the next clock edge.
  - tcb_vld drops even without rdy.
  - uart_txd goes high, truncating any byte in progress.

Test Plan:
- Write: N_BIT=4. Send 80 10 00 00 00 EF BE AD DE; rdy=1. Expect one cycle of tcb_vld with wen=1, adr=0x00000010, wdt=0xDEADBEEF, ben=0xF. Expect UART response 00, busy falling after its stop bit.
- Read with wait states: send 00 04 00 00 00; hold rdy=0 for 5 cycles with vld held stable, then rdy=1. After DLY=1, rdt=0x12345678, err=0. Expect UART response 78 56 34 12 00.
- Bus error: write frame; tcb_err=1 DLY after transfer. Expect response 01.
- Invalid command: send 0x55. Expect response FF, tcb_vld never asserted, FSM back in RX_CMD.
- Framing error: send 00 with stop bit forced 0, then a full valid read frame. Expect only the second frame executed (exactly one vld).
- Reset mid-transfer: assert rst while tcb_vld=1 and rdy=0. Next cycle expect vld=0, uart_txd=1, busy=0. A following write frame completes normally.
